// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the multi-cycle processor controller
// (ctrl_fsm_mc) and its wait-state counter.
//   state_t  : 4-bit controller state encoding (also driven on the debug port)
//   opcode_t : instruction opcodes found in IR[15:12]
//   ALU_*    : ALU_sel codes
//   RFS_*    : register-file write mux select codes
// No ports (package).
// ---------------------------------------------------------------------------
package ctrl_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [3:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_FWAIT  = 4'd2,
      ST_DECODE = 4'd3,
      ST_NOP    = 4'd4,
      ST_LD_RD  = 4'd5,
      ST_LD_WB  = 4'd6,
      ST_STORE  = 4'd7,
      ST_ALU    = 4'd8,
      ST_LDI    = 4'd9,
      ST_JMP    = 4'd10,
      ST_JZ     = 4'd11,
      ST_HALT   = 4'd12
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_STORE = 4'h1,
      OP_LOAD  = 4'h2,
      OP_ADD   = 4'h3,
      OP_SUB   = 4'h4,
      OP_HALT  = 4'h5,
      OP_LDI   = 4'h6,
      OP_JMP   = 4'h7,
      OP_JZ    = 4'h8,
      OP_AND   = 4'h9,
      OP_OR    = 4'hA
   } opcode_t;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;

   localparam logic [1:0] RFS_ALU = 2'd0;
   localparam logic [1:0] RFS_MEM = 2'd1;
   localparam logic [1:0] RFS_IMM = 2'd2;

   // ALU operation selected by a register-register opcode; pass otherwise.
   function automatic logic [2:0] alu_code(input opcode_t op);
      logic [2:0] code;
      code = ALU_PASS;
      case (op)
         OP_ADD:  code = ALU_ADD;
         OP_SUB:  code = ALU_SUB;
         OP_AND:  code = ALU_AND;
         OP_OR:   code = ALU_OR;
         default: code = ALU_PASS;
      endcase
      return code;
   endfunction

   // Opcodes 0xB..0xF are undefined.
   function automatic logic is_legal(input logic [3:0] op);
      return (op <= 4'hA);
   endfunction

endpackage

// File: rtl/ctrl_fsm_mc_if.sv
// ---------------------------------------------------------------------------
// ctrl_fsm_mc_if
// Bundle between the controller and the datapath (IR/PC, RF/ALU, data memory).
//   master modport : the controller (reads IR/zero/go, drives all controls)
//   slave  modport : the datapath side (mirror image)
// Parameter ALU_SEL_W sets the width of ALU_sel.
// Signals: IR[15:0], zero, go in; PC_clr, PC_up, PC_ld, PC_val[7:0], IR_ld,
// D_addr[7:0], D_rd, D_wr, RF_s[1:0], RF_imm[7:0], RF_W_addr[3:0], RF_W_en,
// RF_Ra_addr[3:0], RF_Rb_addr[3:0], ALU_sel, halted, illegal, state[3:0] out.
// ---------------------------------------------------------------------------
interface ctrl_fsm_mc_if
   import ctrl_pkg::*;
#(
   parameter int ALU_SEL_W = 3
);
   logic [15:0]          IR;
   logic                 zero;
   logic                 go;
   logic                 PC_clr;
   logic                 PC_up;
   logic                 PC_ld;
   logic [7:0]           PC_val;
   logic                 IR_ld;
   logic [7:0]           D_addr;
   logic                 D_rd;
   logic                 D_wr;
   logic [1:0]           RF_s;
   logic [7:0]           RF_imm;
   logic [3:0]           RF_W_addr;
   logic                 RF_W_en;
   logic [3:0]           RF_Ra_addr;
   logic [3:0]           RF_Rb_addr;
   logic [ALU_SEL_W-1:0] ALU_sel;
   logic                 halted;
   logic                 illegal;
   logic [STATE_W-1:0]   state;

   modport master (
      input  IR, zero, go,
      output PC_clr, PC_up, PC_ld, PC_val, IR_ld, D_addr, D_rd, D_wr,
             RF_s, RF_imm, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr,
             ALU_sel, halted, illegal, state
   );

   modport slave (
      output IR, zero, go,
      input  PC_clr, PC_up, PC_ld, PC_val, IR_ld, D_addr, D_rd, D_wr,
             RF_s, RF_imm, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr,
             ALU_sel, halted, illegal, state
   );
endinterface

// File: rtl/ctrl_wait_cnt.sv
// ---------------------------------------------------------------------------
// ctrl_wait_cnt
// 3-bit wait-state up-counter shared by the instruction-fetch and data-read
// waits of the controller.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (counter -> 0)
//   i_clr   : synchronous clear (wins over i_en)
//   i_en    : count enable
//   i_term  : terminal value
//   o_tc    : high while the count equals i_term
// ---------------------------------------------------------------------------
module ctrl_wait_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic [2:0] i_term,
   output logic       o_tc
);
   logic [2:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 3'd0;
      end else if (i_clr) begin
         r_cnt <= 3'd0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 3'd1;
      end
   end

   assign o_tc = (r_cnt == i_term);
endmodule

// File: rtl/ctrl_fsm_mc.sv
// ---------------------------------------------------------------------------
// ctrl_fsm_mc
// Multi-cycle control FSM for the 16-bit datapath. Fetches through an
// IMEM_LAT-cycle wait, decodes IR[15:12] and sequences NOP, STORE, LOAD
// (DMEM_LAT read cycles + write-back), ALU ops, LDI, JMP, JZ and HALT.
// Outputs are decoded combinationally from the state and IR.
// Parameters:
//   IMEM_LAT  (0..7) extra fetch wait cycles before IR_ld
//   DMEM_LAT  (1..7) LOAD read cycles before write-back
//   ALU_SEL_W        width of ALU_sel
// Ports:
//   clk       : rising-edge clock
//   Reset     : asynchronous active-low reset
//   step_mode : only with CTRL_STEP_EN defined; when 1, each instruction
//               ends in HALT instead of FETCH so go advances one instruction
//   bus       : ctrl_fsm_mc_if.master (IR/zero/go in, all controls out)
// Build option: `define CTRL_STEP_EN adds the single-step feature.
// ---------------------------------------------------------------------------
module ctrl_fsm_mc
   import ctrl_pkg::*;
#(
   parameter int IMEM_LAT  = 1,
   parameter int DMEM_LAT  = 1,
   parameter int ALU_SEL_W = 3
) (
   input  logic clk,
   input  logic Reset,
`ifdef CTRL_STEP_EN
   input  logic step_mode,
`endif
   ctrl_fsm_mc_if.master bus
);
   // Terminal counts: the counter starts at 0 on entry, so a wait of N
   // cycles finishes when the count reaches N-1.
   localparam logic [2:0] IMEM_TC = (IMEM_LAT == 0) ? 3'd0 : 3'(IMEM_LAT - 1);
   localparam logic [2:0] DMEM_TC = 3'(DMEM_LAT - 1);

   state_t     r_state;
   state_t     w_next;
   state_t     w_ret;
   opcode_t    w_op;
   logic       w_step;
   logic       w_cnt_en;
   logic       w_cnt_tc;
   logic [2:0] w_cnt_term;

`ifdef CTRL_STEP_EN
   assign w_step = step_mode;
`else
   assign w_step = 1'b0;
`endif

   assign w_op  = opcode_t'(bus.IR[15:12]);
   // Where an instruction goes when it completes.
   assign w_ret = w_step ? ST_HALT : ST_FETCH;

   // The counter only runs in the two wait states and is held at 0 elsewhere,
   // so it is already clear on entry to FWAIT or LD_RD.
   assign w_cnt_en   = (r_state == ST_FWAIT) || (r_state == ST_LD_RD);
   assign w_cnt_term = (r_state == ST_LD_RD) ? DMEM_TC : IMEM_TC;

   ctrl_wait_cnt u_wait_cnt (
      .clk    (clk),
      .rst_n  (Reset),
      .i_clr  (!w_cnt_en),
      .i_en   (w_cnt_en),
      .i_term (w_cnt_term),
      .o_tc   (w_cnt_tc)
   );

   // State register
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_INIT:   w_next = ST_FETCH;
         ST_FETCH:  w_next = (IMEM_LAT == 0) ? ST_DECODE : ST_FWAIT;
         ST_FWAIT:  if (w_cnt_tc) w_next = ST_DECODE;
         ST_DECODE: begin
            case (w_op)
               OP_NOP:   w_next = ST_NOP;
               OP_STORE: w_next = ST_STORE;
               OP_LOAD:  w_next = ST_LD_RD;
               OP_ADD,
               OP_SUB,
               OP_AND,
               OP_OR:    w_next = ST_ALU;
               OP_HALT:  w_next = ST_HALT;
               OP_LDI:   w_next = ST_LDI;
               OP_JMP:   w_next = ST_JMP;
               OP_JZ:    w_next = ST_JZ;
               default:  w_next = w_ret;   // undefined opcode
            endcase
         end
         ST_LD_RD:  if (w_cnt_tc) w_next = ST_LD_WB;
         ST_NOP,
         ST_LD_WB,
         ST_STORE,
         ST_ALU,
         ST_LDI,
         ST_JMP,
         ST_JZ:     w_next = w_ret;
         // PC already points past the HALT, so resuming just fetches.
         ST_HALT:   if (bus.go) w_next = ST_FETCH;
         default:   w_next = ST_INIT;
      endcase
   end

   // Output decode. While Reset is low every control is forced to 0; only
   // the debug state (already INIT) is visible.
   always_comb begin
      bus.state      = r_state;
      bus.PC_clr     = 1'b0;
      bus.PC_up      = 1'b0;
      bus.PC_ld      = 1'b0;
      bus.PC_val     = 8'h00;
      bus.IR_ld      = 1'b0;
      bus.D_addr     = 8'h00;
      bus.D_rd       = 1'b0;
      bus.D_wr       = 1'b0;
      bus.RF_s       = RFS_ALU;
      bus.RF_imm     = 8'h00;
      bus.RF_W_addr  = 4'h0;
      bus.RF_W_en    = 1'b0;
      bus.RF_Ra_addr = 4'h0;
      bus.RF_Rb_addr = 4'h0;
      bus.ALU_sel    = '0;
      bus.halted     = 1'b0;
      bus.illegal    = 1'b0;
      if (Reset) begin
         case (r_state)
            ST_INIT:   bus.PC_clr = 1'b1;
            ST_FETCH: begin
               if (IMEM_LAT == 0) begin
                  bus.IR_ld = 1'b1;
                  bus.PC_up = 1'b1;
               end
            end
            ST_FWAIT: begin
               if (w_cnt_tc) begin
                  bus.IR_ld = 1'b1;
                  bus.PC_up = 1'b1;
               end
            end
            ST_DECODE: bus.illegal = !is_legal(bus.IR[15:12]);
            ST_LD_RD: begin
               bus.D_rd   = 1'b1;
               bus.D_addr = bus.IR[11:4];
            end
            ST_LD_WB: begin
               bus.D_addr    = bus.IR[11:4];
               bus.RF_s      = RFS_MEM;
               bus.RF_W_en   = 1'b1;
               bus.RF_W_addr = bus.IR[3:0];
            end
            ST_STORE: begin
               bus.D_wr       = 1'b1;
               bus.D_addr     = bus.IR[7:0];
               bus.RF_Ra_addr = bus.IR[11:8];
            end
            ST_ALU: begin
               bus.RF_s       = RFS_ALU;
               bus.RF_W_en    = 1'b1;
               bus.RF_Ra_addr = bus.IR[11:8];
               bus.RF_Rb_addr = bus.IR[7:4];
               bus.RF_W_addr  = bus.IR[3:0];
               bus.ALU_sel    = ALU_SEL_W'(alu_code(w_op));
            end
            ST_LDI: begin
               bus.RF_s      = RFS_IMM;
               bus.RF_W_en   = 1'b1;
               bus.RF_imm    = bus.IR[11:4];
               bus.RF_W_addr = bus.IR[3:0];
            end
            ST_JMP: begin
               bus.PC_ld  = 1'b1;
               bus.PC_val = bus.IR[7:0];
            end
            ST_JZ: begin
               bus.RF_Ra_addr = bus.IR[11:8];
               bus.PC_ld      = bus.zero;
               bus.PC_val     = bus.IR[7:0];
            end
            ST_HALT:   bus.halted = 1'b1;
            default:   ;
         endcase
      end
   end
endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// ---------------------------------------------------------------------------
// tb_ctrl_fsm_mc
// Randomized bench for ctrl_fsm_mc (IMEM_LAT=2, DMEM_LAT=3). An instruction-
// level model expands each instruction into its expected per-cycle control
// pattern and input stimulus; a runner drives inputs on the falling edge,
// samples 2 ns later and compares against the expected queue.
// ---------------------------------------------------------------------------
module tb_ctrl_fsm_mc;
   import ctrl_pkg::*;

   localparam int IMEM_LAT = 2;
   localparam int DMEM_LAT = 3;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic Reset = 1'b0;
   always #5 clk = ~clk;

   ctrl_fsm_mc_if #(.ALU_SEL_W(3)) bus ();
`ifdef CTRL_STEP_EN
   logic step_mode;
`endif

   ctrl_fsm_mc #(
      .IMEM_LAT  (IMEM_LAT),
      .DMEM_LAT  (DMEM_LAT),
      .ALU_SEL_W (3)
   ) dut (
      .clk       (clk),
      .Reset     (Reset),
`ifdef CTRL_STEP_EN
      .step_mode (step_mode),
`endif
      .bus       (bus)
   );

   // ---------------- observation / stimulus records ----------------
   typedef struct packed {
      logic [3:0] st;
      logic       pc_clr;
      logic       pc_up;
      logic       pc_ld;
      logic [7:0] pc_val;
      logic       ir_ld;
      logic [7:0] d_addr;
      logic       d_rd;
      logic       d_wr;
      logic [1:0] rf_s;
      logic [7:0] rf_imm;
      logic [3:0] w;
      logic       w_en;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] alu;
      logic       halted;
      logic       illegal;
   } obs_t;

   typedef struct packed {
      logic [15:0] ir;
      logic        zero;
      logic        go;
      logic        step;
   } stim_t;

   localparam int OW = $bits(obs_t);

   logic [OW-1:0] exp_q[$];
   stim_t         stim_q[$];
   int            n_checks = 0;
   int            n_err    = 0;
   int            cyc      = 0;

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic obs_t sample_dut();
      obs_t o;
      o.st      = bus.state;
      o.pc_clr  = bus.PC_clr;
      o.pc_up   = bus.PC_up;
      o.pc_ld   = bus.PC_ld;
      o.pc_val  = bus.PC_val;
      o.ir_ld   = bus.IR_ld;
      o.d_addr  = bus.D_addr;
      o.d_rd    = bus.D_rd;
      o.d_wr    = bus.D_wr;
      o.rf_s    = bus.RF_s;
      o.rf_imm  = bus.RF_imm;
      o.w       = bus.RF_W_addr;
      o.w_en    = bus.RF_W_en;
      o.ra      = bus.RF_Ra_addr;
      o.rb      = bus.RF_Rb_addr;
      o.alu     = bus.ALU_sel;
      o.halted  = bus.halted;
      o.illegal = bus.illegal;
      return o;
   endfunction

   // ---------------- reference model ----------------
   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic void push(input obs_t e, input logic [15:0] ir,
                                input logic z, input logic g, input logic s);
      stim_t t;
      t.ir = ir; t.zero = z; t.go = g; t.step = s;
      exp_q.push_back(e);
      stim_q.push_back(t);
   endfunction

   function automatic void push_init();
      obs_t e;
      e = '0;
      e.st = ST_INIT;
      e.pc_clr = 1'b1;
      push(e, 16'h0000, rnd1(), rnd1(), 1'b0);
   endfunction

   // One instruction: fetch (1 + IMEM_LAT cycles), decode, execute, and a
   // HALT stay of halt_n cycles (random when negative) if it halts.
   // zsel: 0/1 force the zero flag in the JZ cycle, 2 = random.
   function automatic void add_instr(input logic [15:0] ir, input int zsel,
                                     input int halt_n, input logic step);
      obs_t       e;
      logic [3:0] op;
      logic       z;
      int         n;
      op = ir[15:12];
      for (int i = 0; i <= IMEM_LAT; i++) begin
         e = '0;
         e.st = (i == 0) ? ST_FETCH : ST_FWAIT;
         if (i == IMEM_LAT) begin
            e.ir_ld = 1'b1;
            e.pc_up = 1'b1;
         end
         push(e, ir, rnd1(), rnd1(), step);
      end
      e = '0;
      e.st = ST_DECODE;
      e.illegal = (op > 4'hA);
      push(e, ir, rnd1(), rnd1(), step);
      e = '0;
      case (op)
         4'h0: begin
            e.st = ST_NOP;
            push(e, ir, rnd1(), rnd1(), step);
         end
         4'h1: begin
            e.st = ST_STORE; e.d_wr = 1'b1; e.d_addr = ir[7:0]; e.ra = ir[11:8];
            push(e, ir, rnd1(), rnd1(), step);
         end
         4'h2: begin
            for (int i = 0; i < DMEM_LAT; i++) begin
               e = '0;
               e.st = ST_LD_RD; e.d_rd = 1'b1; e.d_addr = ir[11:4];
               push(e, ir, rnd1(), rnd1(), step);
            end
            e = '0;
            e.st = ST_LD_WB; e.d_addr = ir[11:4]; e.rf_s = 2'd1; e.w_en = 1'b1; e.w = ir[3:0];
            push(e, ir, rnd1(), rnd1(), step);
         end
         4'h3, 4'h4, 4'h9, 4'hA: begin
            e.st = ST_ALU; e.w_en = 1'b1; e.rf_s = 2'd0;
            e.ra = ir[11:8]; e.rb = ir[7:4]; e.w = ir[3:0];
            e.alu = (op == 4'h3) ? 3'd1 : (op == 4'h4) ? 3'd2 : (op == 4'h9) ? 3'd3 : 3'd4;
            push(e, ir, rnd1(), rnd1(), step);
         end
         4'h6: begin
            e.st = ST_LDI; e.rf_s = 2'd2; e.w_en = 1'b1; e.rf_imm = ir[11:4]; e.w = ir[3:0];
            push(e, ir, rnd1(), rnd1(), step);
         end
         4'h7: begin
            e.st = ST_JMP; e.pc_ld = 1'b1; e.pc_val = ir[7:0];
            push(e, ir, rnd1(), rnd1(), step);
         end
         4'h8: begin
            z = (zsel == 2) ? rnd1() : 1'(zsel);
            e.st = ST_JZ; e.ra = ir[11:8]; e.pc_ld = z; e.pc_val = ir[7:0];
            push(e, ir, z, rnd1(), step);
         end
         default: ;
      endcase
      if (op == 4'h5 || step) begin
         n = (halt_n < 0) ? int'($urandom_range(0, 4)) : halt_n;
         e = '0;
         e.st = ST_HALT; e.halted = 1'b1;
         for (int i = 0; i < n; i++) push(e, ir, rnd1(), 1'b0, step);
         push(e, ir, rnd1(), 1'b1, step);
      end
   endfunction

   // ---------------- driver ----------------
   // Entered and left on a falling edge.
   task automatic step_cycle();
      stim_t s;
      obs_t  e;
      s = stim_q.pop_front();
      e = obs_t'(exp_q.pop_front());
      bus.IR   = s.ir;
      bus.zero = s.zero;
      bus.go   = s.go;
`ifdef CTRL_STEP_EN
      step_mode = s.step;
`endif
      #2;
      check($sformatf("cyc%0d_ir%h_st%0d", cyc, s.ir, e.st), 64'(sample_dut()), 64'(e));
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_all();
      while (exp_q.size() > 0) step_cycle();
   endtask

   task automatic check_reset_state(input string tag);
      obs_t z;
      z = '0;
      z.st = ST_INIT;
      check(tag, 64'(sample_dut()), 64'(z));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bus.IR   = 16'h0000;
      bus.zero = 1'b0;
      bus.go   = 1'b0;
`ifdef CTRL_STEP_EN
      step_mode = 1'b0;
`endif
      Reset = 1'b0;
      repeat (2) @(negedge clk);
      #2 check_reset_state("reset_init");
      @(negedge clk);
      Reset = 1'b1;

      // directed instructions
      push_init();
      add_instr(16'h3536, 2, -1, 1'b0);   // ADD
      add_instr(16'hA125, 2, -1, 1'b0);   // OR
      add_instr(16'h26AA, 2, -1, 1'b0);   // LOAD
      add_instr(16'h8340, 1, -1, 1'b0);   // JZ taken
      add_instr(16'h8340, 0, -1, 1'b0);   // JZ not taken
      add_instr(16'h5000, 2, 10, 1'b0);   // HALT, 10 idle cycles
      add_instr(16'hC000, 2, -1, 1'b0);   // illegal
      add_instr(16'h1A3C, 2, -1, 1'b0);   // STORE
      add_instr(16'h4127, 2, -1, 1'b0);   // SUB
      add_instr(16'h9FE1, 2, -1, 1'b0);   // AND
      add_instr(16'h6FF2, 2, -1, 1'b0);   // LDI
      add_instr(16'h7012, 2, -1, 1'b0);   // JMP
      add_instr(16'h0000, 2, -1, 1'b0);   // NOP
      add_instr(16'hF0F0, 2, -1, 1'b0);   // illegal
      run_all();

      // random instructions
      for (int k = 0; k < 60; k++) begin
         add_instr(16'($urandom_range(0, 65535)), 2, -1, 1'b0);
      end
      run_all();

      // asynchronous reset in the middle of a LOAD read wait
      add_instr(16'h26AA, 2, -1, 1'b0);
      for (int k = 0; k < IMEM_LAT + 1 + 1 + 2; k++) step_cycle();
      #1 Reset = 1'b0;
      #1 check_reset_state("reset_async_ld_rd");
      @(negedge clk);
      #2 check_reset_state("reset_hold");
      @(negedge clk);
      exp_q.delete();
      stim_q.delete();
      Reset = 1'b1;
      push_init();
      add_instr(16'h26AA, 2, -1, 1'b0);
      add_instr(16'h3536, 2, -1, 1'b0);
      run_all();

`ifdef CTRL_STEP_EN
      // single-step: every instruction ends in HALT, go runs the next one
      add_instr(16'h6FF2, 2, 3, 1'b1);
      add_instr(16'h3536, 2, 2, 1'b1);
      add_instr(16'hC000, 2, 1, 1'b1);
      for (int k = 0; k < 10; k++) begin
         add_instr(16'($urandom_range(0, 65535)), 2, -1, 1'b1);
      end
      add_instr(16'h0000, 2, -1, 1'b0);
      run_all();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
